// File: rtl/lc3_mult_pkg.sv
// lc3_mult_pkg: shared types and widths for the LC-3 iterative multiplier.
//   mult_state_t : control FSM states (IDLE, CALC, WB)
//   MULT_W       : operand / write-back width
//   ACC_W        : full product accumulator width
package lc3_mult_pkg;
   localparam int MULT_W = 16;
   localparam int ACC_W  = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      WB   = 2'd2
   } mult_state_t;
endpackage

// File: rtl/nzp_gen.sv
// nzp_gen: combinational LC-3 condition codes of a 16-bit value,
// interpreted as two's complement.
//   val : value under test
//   n   : val negative
//   z   : val zero
//   p   : val strictly positive
module nzp_gen
   import lc3_mult_pkg::*;
(
   input  logic [MULT_W-1:0] val,
   output logic              n,
   output logic              z,
   output logic              p
);
   always_comb begin
      n = val[MULT_W-1];
      z = (val == '0);
      p = !n && !z;
   end
endmodule

// File: rtl/lc3_mult_unit.sv
// lc3_mult_unit: iterative 16x16 unsigned shift-add multiplier sitting
// between the register file read ports and its write port.
//   clk, reset         : clock, asynchronous active-high reset
//   start              : multiply request, only honoured in IDLE
//   dr_in              : destination register, latched with start
//   sr1_val, sr2_val   : multiplicand / multiplier, latched with start
//   busy               : operation in progress (CALC or WB)
//   ld_reg, ld_cc      : one-cycle write-back strobes (WB state)
//   wb_dr, wb_data     : write-back register index and product[15:0]
//   n, z, p            : condition codes of wb_data
//   ovf                : product[31:16] non-zero
// Optional feature macro: LC3_MULT_EARLY_EXIT_EN -- leave CALC as soon as
// the remaining multiplier bits are all zero (variable latency).
module lc3_mult_unit
   import lc3_mult_pkg::*;
#(
   parameter int MULT_ITERS = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        dr_in,
   input  logic [MULT_W-1:0] sr1_val,
   input  logic [MULT_W-1:0] sr2_val,
   output logic              busy,
   output logic              ld_reg,
   output logic [2:0]        wb_dr,
   output logic [MULT_W-1:0] wb_data,
   output logic              ld_cc,
   output logic              n,
   output logic              z,
   output logic              p,
   output logic              ovf
);
   // cnt holds the index of the iteration being performed this cycle
   localparam logic [4:0] LAST_CNT = 5'(MULT_ITERS - 1);

   mult_state_t       state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  mcand_q, mcand_d;
   logic [MULT_W-1:0] mplr_q, mplr_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [2:0]        dr_q, dr_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
         dr_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         cnt_q   <= cnt_d;
         dr_q    <= dr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      cnt_d   = cnt_q;
      dr_d    = dr_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = {{(ACC_W-MULT_W){1'b0}}, sr1_val};
               mplr_d  = sr2_val;
               dr_d    = dr_in;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
`ifdef LC3_MULT_EARLY_EXIT_EN
               // nothing to accumulate: product is the cleared acc
               if (sr2_val == '0) state_d = WB;
`endif
            end
         end
         CALC: begin
            if (mplr_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == LAST_CNT) state_d = WB;
`ifdef LC3_MULT_EARLY_EXIT_EN
            // remaining iterations would add nothing
            if (mplr_d == '0) state_d = WB;
`endif
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // all outputs decode registered state only
   assign busy    = (state_q != IDLE);
   assign ld_reg  = (state_q == WB);
   assign ld_cc   = ld_reg;
   assign wb_dr   = dr_q;
   assign wb_data = acc_q[MULT_W-1:0];
   assign ovf     = |acc_q[ACC_W-1:MULT_W];

   nzp_gen u_nzp (
      .val (wb_data),
      .n   (n),
      .z   (z),
      .p   (p)
   );
endmodule

// File: tb/tb_lc3_mult_unit.sv
module tb_lc3_mult_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  dr_in = '0;
   logic [15:0] sr1_val = '0;
   logic [15:0] sr2_val = '0;
   logic        busy, ld_reg, ld_cc, n, z, p, ovf;
   logic [2:0]  wb_dr;
   logic [15:0] wb_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lc3_mult_unit #(.MULT_ITERS(16)) dut (
      .clk(clk), .reset(reset), .start(start), .dr_in(dr_in),
      .sr1_val(sr1_val), .sr2_val(sr2_val), .busy(busy), .ld_reg(ld_reg),
      .wb_dr(wb_dr), .wb_data(wb_data), .ld_cc(ld_cc),
      .n(n), .z(z), .p(p), .ovf(ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // edges after acceptance until ld_reg is seen
   function automatic int exp_latency(input logic [15:0] b);
      int lat;
`ifdef LC3_MULT_EARLY_EXIT_EN
      lat = 0;
      for (int i = 0; i < 16; i++) if (b[i]) lat = i + 1;
`else
      lat = 16;
`endif
      return lat;
   endfunction

   // inj >= 0: hold a foreign start (dr=7, sr2=0) high across edge E<inj>
   task automatic do_mult(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] d, input logic [15:0] exp_data,
                          input logic en, input logic ez, input logic ep,
                          input logic eovf, input int inj);
      int lat;
      int pulses;
      lat = -1;
      pulses = 0;
      @(negedge clk);
      start = 1'b1; sr1_val = a; sr2_val = b; dr_in = d;
      @(posedge clk); #1;
      start = 1'b0; sr1_val = 16'h5A5A; sr2_val = 16'hA5A5; dr_in = 3'd6;
      chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
      for (int e = 0; e < 40; e++) begin
         if (e == inj - 1) begin
            start = 1'b1; dr_in = 3'd7; sr2_val = 16'h0000;
         end else if (e == inj) begin
            start = 1'b0;
         end
         if (ld_reg) begin
            if (lat < 0) lat = e;
            pulses++;
            chk({tag, "_data"}, 32'(wb_data), 32'(exp_data));
            chk({tag, "_dr"}, 32'(wb_dr), 32'(d));
            chk({tag, "_nzp"}, {29'd0, n, z, p}, {29'd0, en, ez, ep});
            chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
            chk({tag, "_ldcc"}, 32'(ld_cc), 32'd1);
         end
         if (!busy) break;
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk({tag, "_latency"}, 32'(lat), 32'(exp_latency(b)));
      chk({tag, "_pulses"}, 32'(pulses), 32'd1);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int stray;
      // reset state
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ld", {30'd0, ld_reg, ld_cc}, 32'd0);
      chk("rst_wb", {13'd0, wb_dr, wb_data}, 32'd0);
      chk("rst_nzpo", {28'd0, n, z, p, ovf}, 32'b0100);
      @(negedge clk);
      reset = 1'b0;

      do_mult("m3x5",   16'h0003, 16'h0005, 3'd3, 16'h000F, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      do_mult("m100sq", 16'h0100, 16'h0100, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      do_mult("mffffx2",16'hFFFF, 16'h0002, 3'd2, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      do_mult("inj",    16'h0003, 16'h0005, 3'd3, 16'h000F, 1'b0, 1'b0, 1'b1, 1'b0, 5);
      do_mult("m7x3",   16'h0007, 16'h0003, 3'd4, 16'h0015, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      do_mult("mx0",    16'hABCD, 16'h0000, 3'd5, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      do_mult("m3x8000",16'h0003, 16'h8000, 3'd6, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, -1);

      // asynchronous abort between E8 and E9
      @(negedge clk);
      start = 1'b1; sr1_val = 16'h1234; sr2_val = 16'hFFFF; dr_in = 3'd2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ld", 32'(ld_reg), 32'd0);
      chk("abort_data", 32'(wb_data), 32'd0);
      #1;
      reset = 1'b0;
      stray = 0;
      for (int e = 0; e < 24; e++) begin
         @(posedge clk); #1;
         if (ld_reg || busy) stray++;
      end
      chk("abort_quiet", 32'(stray), 32'd0);
      do_mult("post_abort", 16'h0012, 16'h0034, 3'd7, 16'h03A8, 1'b0, 1'b0, 1'b1, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lc3_mult_unit.md
# lc3_mult_unit

Iterative 16×16 unsigned shift-add multiplier for the LC-3 datapath. It sits between the general-purpose register file's read ports and its write port. It takes the SR1/SR2 operand values and a destination register index, computes the product over multiple cycles, then issues a single-cycle write-back (value, DR index, load strobe) plus condition-code results, to be muxed onto the register file's D_In/DR/LD_REG.

## Interface
Parameters:
- `MULT_ITERS`, default 16: maximum number of shift-add iterations, equal to the operand width.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request a multiply; sampled only in IDLE.
- `dr_in` in 3: destination register index, latched with `start`.
- `sr1_val` in 16: multiplicand (register file SR1 output), latched with `start`.
- `sr2_val` in 16: multiplier (register file SR2 output), latched with `start`.
- `busy` out 1: high in CALC and WB.
- `ld_reg` out 1: write-back strobe, high only in WB.
- `wb_dr` out 3: destination index for write-back.
- `wb_data` out 16: product bits [15:0].
- `ld_cc` out 1: condition-code load strobe, identical to `ld_reg`.
- `n`, `z`, `p` out 1 each: NZP of `wb_data`, treating it as two's complement.
- `ovf` out 1: unsigned product bits [31:16] are non-zero.

## Operation
- State machine: IDLE, CALC, WB.
- **IDLE + start:**
  - latch `mcand` (32-bit, zero-extended `sr1_val`), `mplr` = `sr2_val`, `dr` = `dr_in`;
  - clear `acc` (32-bit) and `cnt` (5-bit);
  - go to CALC.
- **IDLE, no start:** stay in IDLE.
- **CALC, each edge:**
  - if `mplr[0]`, add `mcand` to `acc` (mod 2^32);
  - shift `mcand` left by 1; shift `mplr` right by 1, logical;
  - increment `cnt`;
  - when `cnt` reaches `MULT_ITERS`-1 on this edge (i.e. the last iteration completes), go to WB.
- **WB:** one cycle, then go to IDLE unconditionally.
- `start` is ignored whenever the state is not IDLE; latched operands are never disturbed mid-operation.
- **Outputs:**
  - `wb_data` = `acc[15:0]` and `wb_dr` = `dr`, both valid at all times and meaningful in WB;
  - `ovf` = OR of `acc[31:16]`;
  - `n` = `wb_data[15]`; `z` = (`wb_data` == 0); `p` = !`n` && !`z`.
- Operands are unsigned. The low 16 bits equal the two's-complement product regardless of sign.
- **Reset (any state, including mid-CALC or WB):**
  - state goes to IDLE; `acc`, `mcand`, `mplr`, `cnt`, `dr` go to 0;
  - no `ld_reg` pulse is produced for the aborted operation.
- **Reset values:** `busy`=0, `ld_reg`=0, `ld_cc`=0, `wb_dr`=0, `wb_data`=0, `ovf`=0, `n`=0, `z`=1, `p`=0.

## Timing
- Rising edge E0 accepts `start`.
- Iterations occur on E1..E16.
- `ld_reg` is high for exactly one cycle, between E16 and E17.
- The register file captures the result at E17.
- `busy` is high from after E0 until after E17.
- A new `start` is accepted at E17 at the earliest, when the state is IDLE again.
- All outputs are decoded from registered state only; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `LC3_MULT_EARLY_EXIT_EN`.
- **Defined:**
  - CALC exits to WB on the edge where the shifted `mplr` becomes 0.
  - If `sr2_val`==0 at acceptance, go directly IDLE→WB, so `ld_reg` is high between E0 and E1.
  - Latency equals the index of the highest set bit of `sr2_val` plus 1 iterations.
  - Results, including `ovf`, are identical to the full run.
- **Undefined:** always exactly `MULT_ITERS` iterations, i.e. fixed latency.

## Structure
- Package `lc3_mult_pkg` contains:
  - the `mult_state_t` enum (IDLE, CALC, WB);
  - the constants `MULT_W`=16 and `ACC_W`=32.
- Sub-module `nzp_gen`: combinational NZP from a 16-bit value. It is reused by the main datapath's condition-code logic.
- All other logic lives in the top module.

## Test plan
- `sr1`=3, `sr2`=5, `dr`=3, macro off → `ld_reg` high only between E16 and E17; `wb_data`=0x000F, `wb_dr`=3, `p`=1, `ovf`=0.
- `sr1`=0x0100, `sr2`=0x0100 → `wb_data`=0x0000, `z`=1, `ovf`=1.
- `sr1`=0xFFFF, `sr2`=0x0002 → `wb_data`=0xFFFE, `n`=1, `ovf`=1.
- `start` pulsed again at E5 with `dr`=7, `sr2`=0 → ignored; the first result and `wb_dr` are unchanged; exactly one `ld_reg` pulse occurs.
- `reset` asserted asynchronously mid-cycle between E8 and E9 → `busy` and state drop immediately; no `ld_reg` pulse; a following `start` completes normally.
- Macro on: `sr2`=0x0003 → `ld_reg` between E2 and E3. `sr2`=0 → `ld_reg` between E0 and E1 with `wb_data`=0. `sr2`=0x8000 → `ld_reg` between E16 and E17.
